// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Stall/flush sequencer for the five-stage RV32I core. It covers the hazards
//   that forwarding cannot resolve:
//   - load-use: stall F/D and bubble E
//   - taken branch/jump: flush D/E
//   - variable-latency data memory: freeze F..M and bubble W until the memory
//     acknowledges, or until MEM_TIMEOUT frozen cycles have elapsed.
//
//   Optional feature macro: PIPE_PERF_CNT_EN (adds the StallCnt/FlushCnt counters).
//
// Ports
//   clk, rst           core clock; asynchronous active-low reset
//   ResultSrcE0        E-stage instruction is a load
//   RD_E               E-stage destination register
//   Rs1_D, Rs2_D       D-stage source registers
//   PCSrcE             branch/jump taken in E
//   MemReqM            M-stage instruction accesses data memory
//   MemReadyM          data memory completes the access this cycle
//   StallF/D/E/M       hold PC / IF-ID / ID-EX / EX-MEM
//   FlushD/E/W         bubble IF-ID / ID-EX / MEM-WB
//   MemErr             registered one-cycle pulse after a timeout abort
//   StallCnt, FlushCnt saturating performance counters (PIPE_PERF_CNT_EN only)
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ResultSrcE0,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
`ifdef PIPE_PERF_CNT_EN
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`else
    output logic             MemErr
`endif
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              err_nxt;
    logic              lu;
    logic              freeze;

    // state / wait counter / error pulse register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            wcnt   <= '0;
            MemErr <= 1'b0;
        end else begin
            state  <= state_nxt;
            wcnt   <= wcnt_nxt;
            MemErr <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        err_nxt   = 1'b0;
        freeze    = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;

        lu = ResultSrcE0 && (RD_E != 5'd0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

        case (state)
            RUN: begin
                // the entry cycle is the first frozen cycle of the access
                if (MemReqM && !MemReadyM) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                    wcnt_nxt  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                // MemReqM is not looked at here: M still holds the same access
                if (MemReadyM) begin
                    state_nxt = RUN;
                end else if (wcnt == WCNT_MAX) begin
                    // abort: this cycle runs unfrozen, error reported next cycle
                    state_nxt = RUN;
                    err_nxt   = 1'b1;
                end else begin
                    freeze   = 1'b1;
                    wcnt_nxt = wcnt + WCNT_W'(1);
                end
            end
            default: state_nxt = RUN;
        endcase

        // outputs are forced low while reset is held, independent of state
        if (rst) begin
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                // D holds a wrong-path instruction, so a load-use stall is moot
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lu) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallF && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
            if (FlushD && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Pipeline stall/flush sequencer for the five-stage RV32I core. It sits beside the forwarding hazard unit and covers what forwarding cannot:
- load-use hazards, by stalling F/D and bubbling E;
- taken branches/jumps, by flushing D/E;
- variable-latency data-memory accesses, by freezing F–M and bubbling W until the memory acknowledges or a timeout aborts the access.

## Interface
Parameters:
- MEM_TIMEOUT, 15, maximum consecutive frozen cycles for one M-stage access; legal range ≥2.
- CNT_W, 32, width of the performance counters (only with PIPE_PERF_CNT_EN).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ResultSrcE0  in  1  E-stage instruction is a load.
- RD_E  in  5  E-stage destination register.
- Rs1_D, Rs2_D  in  5 each  D-stage source registers.
- PCSrcE  in  1  branch/jump taken in E.
- MemReqM  in  1  M-stage instruction accesses data memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM registers.
- FlushD, FlushE, FlushW  out  1 each  load a bubble into IF-ID / ID-EX / MEM-WB.
- MemErr  out  1  registered one-cycle pulse on memory timeout abort.
- StallCnt, FlushCnt  out  CNT_W each  performance counters (only with PIPE_PERF_CNT_EN).

## Operation
- State machine: RUN (0), MEM_WAIT (1). Wait counter `wcnt` has width clog2(MEM_TIMEOUT+1).
- `lu` = ResultSrcE0 & (RD_E≠0) & ((RD_E==Rs1_D) | (RD_E==Rs2_D)).
- `freeze` is asserted in either of these cases:
  - RUN with MemReqM & !MemReadyM;
  - MEM_WAIT with !MemReadyM & (wcnt≠MEM_TIMEOUT).
- Output priority: rst low → all outputs 0. Otherwise freeze > branch > load-use.
  - freeze: StallF=StallD=StallE=StallM=1, FlushW=1, all other outputs 0.
  - else PCSrcE: FlushD=FlushE=1, no stalls. The branch wins over `lu` because the D instruction is wrong-path.
  - else `lu`: StallF=StallD=1, FlushE=1.
  - else all 0.
- A branch held in E during a freeze keeps PCSrcE high. The flush is issued in the first unfrozen cycle.
- Transitions:
  - RUN → MEM_WAIT when MemReqM & !MemReadyM; `wcnt` ← 1.
  - MEM_WAIT & MemReadyM → RUN (normal completion; that cycle is unfrozen).
  - MEM_WAIT & !MemReadyM & wcnt==MEM_TIMEOUT → RUN (abort; that cycle is unfrozen; MemErr=1 next cycle only).
  - MEM_WAIT & !MemReadyM otherwise: `wcnt` increments.
  - MemReqM is ignored while in MEM_WAIT; the access is the same frozen instruction.
- MemReqM & MemReadyM in RUN is a single-cycle access: no freeze, state stays RUN.

## Timing
- All stall/flush outputs are combinational from inputs and state: zero-cycle latency, same cycle as the condition.
- MemErr is registered.
- Reset values: state RUN, wcnt 0, MemErr 0, counters 0. Every stall/flush output is 0 while rst is low.
- Reset asserted mid-MEM_WAIT: the block returns to RUN and releases the freeze immediately (asynchronous). No MemErr is generated.
- Timeout: an access that never acknowledges is frozen for exactly MEM_TIMEOUT cycles, counting the entry cycle. The next cycle is unfrozen, and MemErr pulses in the cycle after that.
- Back-to-back accesses: a new M instruction with MemReqM & !MemReadyM in the cycle right after returning to RUN re-enters MEM_WAIT normally.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - StallCnt increments on each cycle with StallF=1.
  - FlushCnt increments on each cycle with FlushD=1.
  - Both are saturating at all-ones and cleared only by reset.
- PIPE_PERF_CNT_EN undefined: StallCnt and FlushCnt ports and their registers are absent. Behaviour is otherwise identical.

## Test plan
- Load-use: ResultSrcE0=1, RD_E=5, Rs2_D=5, no memory request → StallF=StallD=FlushE=1 for that cycle. With RD_E=0 → all outputs 0.
- Branch + load-use same cycle: PCSrcE=1 with `lu` true → FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM low for 3 cycles then high → StallF/D/E/M and FlushW high for 3 cycles, low on the ready cycle, state back to RUN, MemErr stays 0.
- Timeout with MEM_TIMEOUT=4 and MemReadyM stuck low → freeze for exactly 4 cycles, unfrozen 5th cycle, MemErr=1 on the 6th cycle only.
- Reset mid-wait: drop rst in the 2nd frozen cycle → all outputs 0 immediately. After release, state is RUN and MemErr is 0.
- With PIPE_PERF_CNT_EN: 2 load-use stalls plus 3 frozen cycles → StallCnt=5. One branch → FlushCnt=1.
